spi_xfer_scheduler: RTL and testbench
=====================================

# spi_xfer_scheduler

Transaction controller and round-robin arbiter for the single-master, three-slave SPI shift datapath. Three requesters, one per slave, each ask for a full-byte exchange with their slave. The scheduler grants one requester at a time and sequences the datapath's load strobe and slave selects (ss0/ss1/ss2) so that load and shifting never overlap. After SHIFT_LEN shifts it captures the byte returned from the slave and hands it back to the requester with a one-cycle acknowledge.

## Interface
Parameters:
- SHIFT_LEN, 8: shift cycles per transfer; must equal the datapath register width.
- CNT_W, 4: shift-counter width; must satisfy 2^CNT_W > SHIFT_LEN.

Ports:
- clk  in  1  single clock, all state on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- req  in  3  level request; bit k = exchange with slave k. Held high until the matching ack is seen.
- tx_data0, tx_data1, tx_data2  in  8  byte to send for requester 0/1/2. Sampled only at grant.
- abort  in  1  synchronous cancel of the transfer in progress.
- dp_master_data  in  8  master register of the datapath, [0:7] ordering.
- dp_load  out  1  load strobe to the datapath.
- dp_data  out  8  byte presented on the datapath data input.
- dp_ss0, dp_ss1, dp_ss2  out  1  slave selects to the datapath; at most one is high.
- busy  out  1  high in every state except IDLE.
- ack  out  3  one-cycle completion pulse to the granted requester.
- rx_data  out  8  byte received from the slave; valid while ack is high and held until the next capture.

## Operation
- FSM states: IDLE, LOAD, SHIFT, CAPT, ACK.
- **IDLE:** if any req bit is high, the arbiter grants and the FSM moves to LOAD. At the same edge:
  - grant index g is registered;
  - tx_data[g] is latched into the dp_data hold register;
  - the round-robin pointer is set to g.
- **Arbitration:** round-robin. The search starts at pointer+1 mod 3. The pointer resets to 2, so requester 0 has first priority after reset.
- **LOAD:** dp_load=1 and all ss low for exactly one cycle. Shift counter cleared. Then SHIFT.
- **SHIFT:** dp_ss[g]=1 and dp_load=0 for exactly SHIFT_LEN cycles. The counter increments each cycle; on count SHIFT_LEN-1 the FSM moves to CAPT.
- **CAPT:** all ss low. rx_data <= dp_master_data at the end of the cycle. Then ACK.
- **ACK:** ack[g]=1 for one cycle, then IDLE. No new grant is made in ACK.
- **abort:**
  - In LOAD, SHIFT or CAPT: at the next edge go to IDLE. Selects drop, no ack, rx_data unchanged, pointer remains g (fairness is preserved).
  - In IDLE or ACK: abort is ignored.
- **Inputs ignored outside IDLE:** req changes and tx_data changes have no effect until the FSM returns to IDLE.
- **Output invariants:** dp_load and any dp_ss are never high in the same cycle. At most one of dp_ss0..2 is high at any time.
- **Reset (rst_n low, any time including mid-transfer):**
  - state=IDLE, pointer=2, counter=0;
  - dp_load=0, dp_data=0, all dp_ss=0;
  - busy=0, ack=0, rx_data=0.
  - Outputs reach these values immediately, with no clock needed.
- **Outputs are registered** (decoded from state registers); no combinational path from req or abort to any output.

## Timing
- Edge E0 samples req in IDLE.
- Cycle sequence after E0:
  - cycle 1: LOAD;
  - cycles 2..SHIFT_LEN+1: SHIFT;
  - cycle SHIFT_LEN+2: CAPT;
  - cycle SHIFT_LEN+3: ACK.
- Request to ack is SHIFT_LEN+3 cycles (11 at default).
- The next grant is at earliest from the IDLE cycle after ACK. Back-to-back period is SHIFT_LEN+4 cycles (12).
- Requester rule: deassert req on the edge that samples ack high, so req is low during the following IDLE cycle.
- Simultaneous requests in IDLE are resolved in one cycle by round-robin order.
- Request while busy: waits, no loss, no queue depth beyond the req level.
- busy rises at the edge entering LOAD and falls at the edge entering IDLE.

## Test plan
- **Reset:** pulse rst_n low mid-SHIFT with dp_ss1 high. Required: all outputs go to 0 asynchronously and the FSM is in IDLE; after release, req=3'b001 is granted to requester 0.
- **Single transfer:** tx_data0=8'hA5, slave0 preloaded 8'h3C, req=3'b001. Required:
  - dp_load high exactly 1 cycle;
  - dp_ss0 high 8 cycles;
  - ack=3'b001 in cycle 11;
  - rx_data=8'h3C;
  - slave0 ends holding 8'hA5.
- **Simultaneous requests:** req=3'b111 held, each requester dropping its bit after its ack. Required: grant order 0, 1, 2; acks 12 cycles apart; dp_ss0..2 never overlap.
- **Fairness:** requester 0 re-requests immediately after each ack while req2 stays high. Required: requester 2 is served before requester 0's second transfer.
- **Abort:** abort=1 in the 4th SHIFT cycle of a requester-1 transfer. Required:
  - dp_ss1 low at the next edge, FSM in IDLE, no ack;
  - rx_data holds its previous value;
  - a pending req0 is granted next.
- **Isolation:** change tx_data0 from 8'h11 to 8'hFF during SHIFT. Required: the slave receives 8'h11; a check asserts dp_load & |dp_ss never occurs.

Source files
------------

// File: rtl/spi_xfer_scheduler.sv
// Transaction controller and round-robin arbiter for a 1-master, 3-slave SPI shift datapath.
// It grants one requester at a time, strobes the datapath load, and then drives that requester's
// slave select for SHIFT_LEN cycles. It then captures the returned byte and pulses ack.
module spi_xfer_scheduler #(
    parameter int unsigned SHIFT_LEN = 8,
    parameter int unsigned CNT_W     = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] req,
    input  logic [7:0] tx_data0,
    input  logic [7:0] tx_data1,
    input  logic [7:0] tx_data2,
    input  logic       abort,
    input  logic [7:0] dp_master_data,
    output logic       dp_load,
    output logic [7:0] dp_data,
    output logic       dp_ss0,
    output logic       dp_ss1,
    output logic       dp_ss2,
    output logic       busy,
    output logic [2:0] ack,
    output logic [7:0] rx_data
);

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StShift,
        StCapt,
        StAck
    } state_e;

    localparam logic [CNT_W-1:0] LastCnt = CNT_W'(SHIFT_LEN - 1);

    state_e           state_q, state_d;
    logic [1:0]       grant_q, grant_d;
    logic [1:0]       ptr_q, ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       data_q, data_d;
    logic [7:0]       rx_q, rx_d;

    logic       arb_valid;
    logic [1:0] arb_idx;
    logic [7:0] arb_tx;

    // Round-robin search starting one past the last grant (pointer), wrapping mod 3.
    always_comb begin
        arb_valid = 1'b0;
        arb_idx   = 2'd0;
        for (int i = 1; i <= 3; i++) begin
            int cand;
            cand = (int'(ptr_q) + i) % 3;
            if (!arb_valid && req[cand]) begin
                arb_valid = 1'b1;
                arb_idx   = 2'(cand);
            end
        end
        unique case (arb_idx)
            2'd0:    arb_tx = tx_data0;
            2'd1:    arb_tx = tx_data1;
            default: arb_tx = tx_data2;
        endcase
    end

    // Next-state: sequence LOAD -> SHIFT x SHIFT_LEN -> CAPT -> ACK; abort cancels before ACK.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        rx_d    = rx_q;
        unique case (state_q)
            StIdle: begin
                if (arb_valid) begin
                    state_d = StLoad;
                    grant_d = arb_idx;
                    ptr_d   = arb_idx;
                    data_d  = arb_tx;
                end
            end
            StLoad: begin
                cnt_d   = '0;
                state_d = abort ? StIdle : StShift;
            end
            StShift: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (abort) begin
                    state_d = StIdle;
                end else if (cnt_q == LastCnt) begin
                    state_d = StCapt;
                end
            end
            StCapt: begin
                if (abort) begin
                    state_d = StIdle;
                end else begin
                    rx_d    = dp_master_data;
                    state_d = StAck;
                end
            end
            StAck: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State registers; reset leaves requester 0 first in line (pointer = 2).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            grant_q <= 2'd0;
            ptr_q   <= 2'd2;
            cnt_q   <= '0;
            data_q  <= 8'h00;
            rx_q    <= 8'h00;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            rx_q    <= rx_d;
        end
    end

    // Outputs decoded only from registered state, so req/abort never reach them combinationally.
    always_comb begin
        dp_load = (state_q == StLoad);
        dp_ss0  = (state_q == StShift) && (grant_q == 2'd0);
        dp_ss1  = (state_q == StShift) && (grant_q == 2'd1);
        dp_ss2  = (state_q == StShift) && (grant_q == 2'd2);
        busy    = (state_q != StIdle);
        ack     = 3'b000;
        if (state_q == StAck) begin
            ack[grant_q] = 1'b1;
        end
        dp_data = data_q;
        rx_data = rx_q;
    end

endmodule

// File: tb/tb_spi_xfer_scheduler.sv
// Directed bench for spi_xfer_scheduler with a behavioural 3-slave SPI shift datapath model.
module tb_spi_xfer_scheduler;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [2:0] req = 3'b000;
    logic [7:0] tx0 = 8'h00;
    logic [7:0] tx1 = 8'h00;
    logic [7:0] tx2 = 8'h00;
    logic       abort = 1'b0;
    logic [7:0] master = 8'h00;
    logic [7:0] slv [3] = '{8'h00, 8'h00, 8'h00};

    logic       dp_load;
    logic [7:0] dp_data;
    logic       ss0, ss1, ss2;
    logic       busy;
    logic [2:0] ack;
    logic [7:0] rx_data;

    logic       pre_en = 1'b0;
    int         pre_idx = 0;
    logic [7:0] pre_val = 8'h00;

    int checks = 0;
    int failures = 0;
    int overlap_errs = 0;

    always #5 clk = ~clk;

    spi_xfer_scheduler dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req            (req),
        .tx_data0       (tx0),
        .tx_data1       (tx1),
        .tx_data2       (tx2),
        .abort          (abort),
        .dp_master_data (master),
        .dp_load        (dp_load),
        .dp_data        (dp_data),
        .dp_ss0         (ss0),
        .dp_ss1         (ss1),
        .dp_ss2         (ss2),
        .busy           (busy),
        .ack            (ack),
        .rx_data        (rx_data)
    );

    // Datapath model: load the master, or exchange one bit with the selected slave per cycle.
    always @(posedge clk) begin
        if (pre_en) begin
            slv[pre_idx] <= pre_val;
        end else if (dp_load) begin
            master <= dp_data;
        end else if (ss0) begin
            master <= {master[6:0], slv[0][7]};
            slv[0] <= {slv[0][6:0], master[7]};
        end else if (ss1) begin
            master <= {master[6:0], slv[1][7]};
            slv[1] <= {slv[1][6:0], master[7]};
        end else if (ss2) begin
            master <= {master[6:0], slv[2][7]};
            slv[2] <= {slv[2][6:0], master[7]};
        end
    end

    // Output invariants watched on every cycle.
    always @(negedge clk) begin
        if (rst_n) begin
            if (dp_load && (ss0 || ss1 || ss2)) overlap_errs++;
            if ($countones({ss0, ss1, ss2}) > 1) overlap_errs++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input int k, input logic [7:0] v);
        pre_en  = 1'b1;
        pre_idx = k;
        pre_val = v;
        step();
        pre_en  = 1'b0;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        req   = 3'b000;
        abort = 1'b0;
        #2;
        rst_n = 1'b1;
        step();
    endtask

    task automatic run_until_ack(input int max, output int cyc, output logic [2:0] a);
        cyc = -1;
        a   = 3'b000;
        for (int c = 1; c <= max; c++) begin
            step();
            if (ack !== 3'b000) begin
                cyc = c;
                a   = ack;
                break;
            end
        end
    endtask

    task automatic test_reset();
        int         cyc;
        logic [2:0] a;
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if ({dp_load, dp_data, ss0, ss1, ss2, busy, ack, rx_data} !== 23'd0) begin
            failures++;
            $display("FAIL reset_initial got=%h want=0",
                     {dp_load, dp_data, ss0, ss1, ss2, busy, ack, rx_data});
        end
        #10 rst_n = 1'b1;
        step();
        tx1 = 8'hC3;
        req = 3'b010;
        step();
        step();
        step();
        checks++;
        if (ss1 !== 1'b1) begin
            failures++;
            $display("FAIL reset_setup_ss1 got=%b want=1", ss1);
        end
        rst_n = 1'b0;
        req   = 3'b000;
        #2;
        checks++;
        if ({dp_load, dp_data, ss0, ss1, ss2, busy, ack, rx_data} !== 23'd0) begin
            failures++;
            $display("FAIL reset_async got=%h want=0",
                     {dp_load, dp_data, ss0, ss1, ss2, busy, ack, rx_data});
        end
        #2 rst_n = 1'b1;
        req = 3'b001;
        step();
        checks++;
        if (dp_load !== 1'b1) begin
            failures++;
            $display("FAIL reset_regrant_load got=%b want=1", dp_load);
        end
        step();
        checks++;
        if ({ss2, ss1, ss0} !== 3'b001) begin
            failures++;
            $display("FAIL reset_regrant_ss got=%b want=001", {ss2, ss1, ss0});
        end
        run_until_ack(20, cyc, a);
        req = 3'b000;
        checks++;
        if (a !== 3'b001) begin
            failures++;
            $display("FAIL reset_regrant_ack got=%b want=001", a);
        end
        step();
    endtask

    task automatic test_single();
        int         load_cnt = 0;
        int         ss0_cnt = 0;
        int         ack_cyc = -1;
        int         bad_ack = 0;
        logic [7:0] rx_at_ack = 8'h00;
        apply_reset();
        preload(0, 8'h3C);
        tx0 = 8'hA5;
        req = 3'b001;
        for (int c = 1; c <= 13; c++) begin
            step();
            if (dp_load) load_cnt++;
            if (ss0) ss0_cnt++;
            if (ack == 3'b001 && ack_cyc < 0) begin
                ack_cyc   = c;
                rx_at_ack = rx_data;
                req       = 3'b000;
            end else if (ack != 3'b000) begin
                bad_ack++;
            end
        end
        checks++;
        if (load_cnt !== 1) begin
            failures++;
            $display("FAIL single_load_cycles got=%0d want=1", load_cnt);
        end
        checks++;
        if (ss0_cnt !== 8) begin
            failures++;
            $display("FAIL single_ss0_cycles got=%0d want=8", ss0_cnt);
        end
        checks++;
        if (ack_cyc !== 11) begin
            failures++;
            $display("FAIL single_ack_cycle got=%0d want=11", ack_cyc);
        end
        checks++;
        if (rx_at_ack !== 8'h3C) begin
            failures++;
            $display("FAIL single_rx got=%h want=3c", rx_at_ack);
        end
        checks++;
        if (slv[0] !== 8'hA5) begin
            failures++;
            $display("FAIL single_slave0 got=%h want=a5", slv[0]);
        end
        checks++;
        if (bad_ack !== 0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL single_idle got=bad_ack:%0d busy:%b want=0/0", bad_ack, busy);
        end
    endtask

    task automatic test_simultaneous();
        int         n = 0;
        logic [2:0] seq [3];
        int         cyc [3];
        logic [7:0] rxv [3];
        apply_reset();
        overlap_errs = 0;
        preload(0, 8'h10);
        preload(1, 8'h21);
        preload(2, 8'h32);
        tx0 = 8'h01;
        tx1 = 8'h02;
        tx2 = 8'h03;
        req = 3'b111;
        for (int c = 1; c <= 60; c++) begin
            step();
            if (ack !== 3'b000 && n < 3) begin
                seq[n] = ack;
                cyc[n] = c;
                rxv[n] = rx_data;
                req    = req & ~ack;
                n++;
            end
        end
        checks++;
        if (n !== 3) begin
            failures++;
            $display("FAIL simul_ack_count got=%0d want=3", n);
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (seq[i] !== 3'(1 << i) || cyc[i] !== 11 + 12 * i) begin
                    failures++;
                    $display("FAIL simul_order[%0d] got=ack:%b cyc:%0d want=ack:%b cyc:%0d",
                             i, seq[i], cyc[i], 3'(1 << i), 11 + 12 * i);
                end
            end
            checks++;
            if (rxv[0] !== 8'h10 || rxv[1] !== 8'h21 || rxv[2] !== 8'h32) begin
                failures++;
                $display("FAIL simul_rx got=%h %h %h want=10 21 32", rxv[0], rxv[1], rxv[2]);
            end
        end
        checks++;
        if (slv[1] !== 8'h02 || overlap_errs !== 0) begin
            failures++;
            $display("FAIL simul_slave1_overlap got=%h/%0d want=02/0", slv[1], overlap_errs);
        end
    endtask

    task automatic test_fairness();
        int         n = 0;
        logic       reraise = 1'b0;
        logic [2:0] seq [3];
        apply_reset();
        req = 3'b101;
        for (int c = 1; c <= 60; c++) begin
            step();
            if (reraise) begin
                req[0]  = 1'b1;
                reraise = 1'b0;
            end
            if (ack !== 3'b000 && n < 3) begin
                seq[n] = ack;
                req    = req & ~ack;
                n++;
                if (ack[0] && n < 3) reraise = 1'b1;
            end
        end
        checks++;
        if (n !== 3 || seq[0] !== 3'b001 || seq[1] !== 3'b100 || seq[2] !== 3'b001) begin
            failures++;
            $display("FAIL fairness_order got=n:%0d %b %b %b want=3 001 100 001",
                     n, seq[0], seq[1], seq[2]);
        end
    endtask

    task automatic test_abort();
        int         cyc;
        logic [2:0] a;
        apply_reset();
        preload(0, 8'h77);
        tx0 = 8'h44;
        req = 3'b001;
        run_until_ack(20, cyc, a);
        req = 3'b000;
        checks++;
        if (a !== 3'b001 || rx_data !== 8'h77) begin
            failures++;
            $display("FAIL abort_setup got=ack:%b rx:%h want=001/77", a, rx_data);
        end
        step();
        tx1 = 8'h5A;
        req = 3'b010;
        step();
        step();
        req[0] = 1'b1;
        step();
        step();
        step();
        checks++;
        if (ss1 !== 1'b1) begin
            failures++;
            $display("FAIL abort_shift4_ss1 got=%b want=1", ss1);
        end
        abort = 1'b1;
        step();
        abort = 1'b0;
        checks++;
        if (ss1 !== 1'b0 || busy !== 1'b0 || ack !== 3'b000 || rx_data !== 8'h77) begin
            failures++;
            $display("FAIL abort_cancel got=ss1:%b busy:%b ack:%b rx:%h want=0/0/000/77",
                     ss1, busy, ack, rx_data);
        end
        step();
        step();
        checks++;
        if ({ss2, ss1, ss0} !== 3'b001) begin
            failures++;
            $display("FAIL abort_next_grant got=%b want=001", {ss2, ss1, ss0});
        end
        run_until_ack(15, cyc, a);
        req = 3'b000;
        checks++;
        if (a !== 3'b001 || rx_data !== 8'h44) begin
            failures++;
            $display("FAIL abort_next_ack got=ack:%b rx:%h want=001/44", a, rx_data);
        end
        step();
    endtask

    task automatic test_isolation();
        int         cyc;
        logic [2:0] a;
        apply_reset();
        overlap_errs = 0;
        preload(0, 8'h00);
        tx0 = 8'h11;
        req = 3'b001;
        step();
        step();
        step();
        tx0 = 8'hFF;
        run_until_ack(20, cyc, a);
        req = 3'b000;
        checks++;
        if (a !== 3'b001 || cyc !== 8) begin
            failures++;
            $display("FAIL iso_ack got=ack:%b cyc:%0d want=001/8", a, cyc);
        end
        checks++;
        if (slv[0] !== 8'h11 || dp_data !== 8'h11 || rx_data !== 8'h00) begin
            failures++;
            $display("FAIL iso_data got=slv:%h dp:%h rx:%h want=11/11/00",
                     slv[0], dp_data, rx_data);
        end
        step();
        req = 3'b001;
        run_until_ack(20, cyc, a);
        req = 3'b000;
        checks++;
        if (slv[0] !== 8'hFF || rx_data !== 8'h11) begin
            failures++;
            $display("FAIL iso_second got=slv:%h rx:%h want=ff/11", slv[0], rx_data);
        end
        checks++;
        if (overlap_errs !== 0) begin
            failures++;
            $display("FAIL iso_load_ss_overlap got=%0d want=0", overlap_errs);
        end
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog_timeout got=running want=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_simultaneous();
        test_fairness();
        test_abort();
        test_isolation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
